calc1_port_responder: RTL and testbench

CALC1_PORT_RESPONDER -- requirements
Module: calc1_port_responder

---
 rtl/calc1_port_responder.sv | 131 +++++++++++++
 tb/tb_calc1_port_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/calc1_port_responder.sv
// Two-operand command responder: ADD/SUB (and LSH/RSH when CALC1_SHIFT_EN is defined),
// with a fixed five-state sequence and a registered one-cycle response.
module calc1_port_responder (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        out_busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OPND2 = 3'd1;
  localparam logic [2:0] ST_EXEC1 = 3'd2;
  localparam logic [2:0] ST_EXEC2 = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
`ifdef CALC1_SHIFT_EN
  localparam logic [0:3] CMD_LSH = 4'd5;
  localparam logic [0:3] CMD_RSH = 4'd6;
`endif

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;
  localparam logic [0:1] RESP_INT  = 2'd3;

  logic [2:0]  r_state;
  logic [0:3]  r_cmd;
  logic [0:31] r_op1;
  logic [0:31] r_op2;
  logic [0:1]  r_res_resp;
  logic [0:31] r_res_data;
  logic [0:1]  r_out_resp;
  logic [0:31] r_out_data;

  logic [32:0] w_sum;
  logic        w_borrow;
  logic [0:1]  w_calc_resp;
  logic [0:31] w_calc_data;

  // Bit 0 is the MSB, so arithmetic and shifts operate on the plain numeric value.
  always_comb begin
    w_sum       = {1'b0, r_op1} + {1'b0, r_op2};
    w_borrow    = (r_op2 > r_op1);
    w_calc_resp = RESP_ERR;
    w_calc_data = '0;
    case (r_cmd)
      CMD_ADD: begin
        if (!w_sum[32]) begin
          w_calc_resp = RESP_OK;
          w_calc_data = w_sum[31:0];
        end
      end
      CMD_SUB: begin
        if (!w_borrow) begin
          w_calc_resp = RESP_OK;
          w_calc_data = r_op1 - r_op2;
        end
      end
`ifdef CALC1_SHIFT_EN
      CMD_LSH: begin
        w_calc_resp = RESP_OK;
        w_calc_data = r_op1 << r_op2[27:31];
      end
      CMD_RSH: begin
        w_calc_resp = RESP_OK;
        w_calc_data = r_op1 >> r_op2[27:31];
      end
`endif
      default: ;
    endcase
  end

  // Outputs are loaded on the edge that leaves RESP, which places the response in
  // the cycle four edges after the command edge while the FSM is already IDLE.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_res_resp <= RESP_NONE;
      r_res_data <= '0;
      r_out_resp <= RESP_NONE;
      r_out_data <= '0;
    end else begin
      r_out_resp <= RESP_NONE;
      r_out_data <= '0;
      case (r_state)
        ST_IDLE: begin
          if (req_cmd_in != CMD_NOP) begin
            r_cmd   <= req_cmd_in;
            r_op1   <= req_data_in;
            r_state <= ST_OPND2;
          end
        end
        ST_OPND2: begin
          r_op2   <= req_data_in;
          r_state <= ST_EXEC1;
        end
        ST_EXEC1: begin
          r_res_resp <= w_calc_resp;
          r_res_data <= w_calc_data;
          r_state    <= ST_EXEC2;
        end
        ST_EXEC2: begin
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_out_resp <= r_res_resp;
          r_out_data <= r_res_data;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_out_resp <= RESP_INT;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_resp = r_out_resp;
  assign out_data = r_out_data;
  assign out_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed bench for calc1_port_responder; shift expectations follow CALC1_SHIFT_EN.
module tb_calc1_port_responder;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        out_busy;

  int n_err;
  int n_checks;

  calc1_port_responder dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_busy    (out_busy)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and check every cycle up to one cycle past the response.
  task automatic run_cmd(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [1:0] er, input logic [31:0] ed, input string tag);
    @(negedge c_clk); req_cmd_in = cmd; req_data_in = op1;
    @(posedge c_clk); #1;
    check({tag, "_busy_t0"}, {31'd0, out_busy}, 32'd1);
    @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = op2;
    @(posedge c_clk); #1;
    check({tag, "_resp_t1"}, {30'd0, out_resp}, 32'd0);
    @(negedge c_clk); req_data_in = 32'hDEAD_BEEF;
    @(posedge c_clk); #1;
    check({tag, "_resp_t2"}, {30'd0, out_resp}, 32'd0);
    @(posedge c_clk); #1;
    check({tag, "_resp_t3"}, {30'd0, out_resp}, 32'd0);
    check({tag, "_busy_t3"}, {31'd0, out_busy}, 32'd1);
    @(posedge c_clk); #1;
    check({tag, "_resp"}, {30'd0, out_resp}, {30'd0, er});
    check({tag, "_data"}, out_data, ed);
    check({tag, "_busy_t4"}, {31'd0, out_busy}, 32'd0);
    @(posedge c_clk); #1;
    check({tag, "_resp_t5"}, {30'd0, out_resp}, 32'd0);
    check({tag, "_data_t5"}, out_data, 32'd0);
  endtask

  initial begin
    logic [1:0]  sh_resp;
    logic [31:0] lsh_data;
    logic [31:0] rsh_data;
    logic [31:0] sh0_data;
    n_err = 0;
    n_checks = 0;
`ifdef CALC1_SHIFT_EN
    sh_resp  = 2'd1;
    lsh_data = 32'h8000_0000;
    rsh_data = 32'h1000_0000;
    sh0_data = 32'h0000_1234;
`else
    sh_resp  = 2'd2;
    lsh_data = 32'h0;
    rsh_data = 32'h0;
    sh0_data = 32'h0;
`endif

    // Reset held across a clock edge with a command present.
    reset = 1'b0; req_cmd_in = 4'd1; req_data_in = 32'd5;
    #12;
    check("rst_busy", {31'd0, out_busy}, 32'd0);
    check("rst_resp", {30'd0, out_resp}, 32'd0);
    check("rst_data", out_data, 32'd0);
    @(negedge c_clk); reset = 1'b1; req_cmd_in = 4'd0;

    run_cmd(4'd1, 32'd255,        32'd1,          2'd1, 32'd256,      "add_255_1");
    run_cmd(4'd1, 32'hFFFF_FFFF,  32'd1,          2'd2, 32'd0,        "add_ovf");
    run_cmd(4'd1, 32'h7FFF_FFFF,  32'h8000_0000,  2'd1, 32'hFFFF_FFFF,"add_max");
    run_cmd(4'd2, 32'd1,          32'd2,          2'd2, 32'd0,        "sub_borrow");
    run_cmd(4'd2, 32'd100,        32'd1,          2'd1, 32'd99,       "sub_100_1");
    run_cmd(4'd2, 32'd5,          32'd5,          2'd1, 32'd0,        "sub_equal");
    run_cmd(4'd5, 32'd1,          32'd31,         sh_resp, lsh_data,  "lsh_31");
    run_cmd(4'd6, 32'h8000_0000,  32'd35,         sh_resp, rsh_data,  "rsh_35");
    run_cmd(4'd5, 32'h0000_1234,  32'd32,         sh_resp, sh0_data,  "lsh_0");
    run_cmd(4'd3, 32'd7,          32'd7,          2'd2, 32'd0,        "cmd3");
    run_cmd(4'd15, 32'd9,         32'd9,          2'd2, 32'd0,        "cmd15");

    // ADD, then a SUB presented during EXEC1, then a command right after RESP.
    @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd10;
    @(posedge c_clk); #1; check("b2b_busy1", {31'd0, out_busy}, 32'd1);
    @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd20;
    @(posedge c_clk); #1; check("b2b_busy2", {31'd0, out_busy}, 32'd1);
    @(negedge c_clk); req_cmd_in = 4'd2; req_data_in = 32'd50;
    @(posedge c_clk); #1; check("b2b_busy3", {31'd0, out_busy}, 32'd1);
    check("b2b_resp3", {30'd0, out_resp}, 32'd0);
    @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd1;
    @(posedge c_clk); #1; check("b2b_busy4", {31'd0, out_busy}, 32'd1);
    check("b2b_resp4", {30'd0, out_resp}, 32'd0);
    @(posedge c_clk); #1;
    check("b2b_add_resp", {30'd0, out_resp}, 32'd1);
    check("b2b_add_data", out_data, 32'd30);
    check("b2b_busy5", {31'd0, out_busy}, 32'd0);
    @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd3;
    @(posedge c_clk); #1; check("b2b_next_busy", {31'd0, out_busy}, 32'd1);
    check("b2b_no_sub", {30'd0, out_resp}, 32'd0);
    @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd4;
    repeat (3) begin
      @(posedge c_clk); #1; check("b2b_next_wait", {30'd0, out_resp}, 32'd0);
    end
    @(posedge c_clk); #1;
    check("b2b_next_resp", {30'd0, out_resp}, 32'd1);
    check("b2b_next_data", out_data, 32'd7);
    @(posedge c_clk); #1; check("b2b_quiet", {30'd0, out_resp}, 32'd0);

    // Reset during EXEC2 aborts with no response; accept on first edge after release.
    @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd1;
    @(posedge c_clk);
    @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd1;
    @(posedge c_clk);
    @(posedge c_clk); #1;
    check("abort_busy_pre", {31'd0, out_busy}, 32'd1);
    #2; reset = 1'b0; #1;
    check("abort_busy", {31'd0, out_busy}, 32'd0);
    check("abort_resp", {30'd0, out_resp}, 32'd0);
    check("abort_data", out_data, 32'd0);
    @(posedge c_clk); #1; check("abort_held", {30'd0, out_resp}, 32'd0);
    @(negedge c_clk); reset = 1'b1; req_cmd_in = 4'd1; req_data_in = 32'd40;
    @(posedge c_clk); #1; check("abort_accept", {31'd0, out_busy}, 32'd1);
    @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd2;
    repeat (3) begin
      @(posedge c_clk); #1; check("abort_no_resp", {30'd0, out_resp}, 32'd0);
    end
    @(posedge c_clk); #1;
    check("abort_new_resp", {30'd0, out_resp}, 32'd1);
    check("abort_new_data", out_data, 32'd42);

    // Reset during the response cycle clears the outputs without a clock edge.
    @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd5;
    @(posedge c_clk);
    @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd6;
    repeat (4) @(posedge c_clk);
    #1;
    check("rresp_resp_pre", {30'd0, out_resp}, 32'd1);
    check("rresp_data_pre", out_data, 32'd11);
    #2; reset = 1'b0; #1;
    check("rresp_resp", {30'd0, out_resp}, 32'd0);
    check("rresp_data", out_data, 32'd0);
    @(negedge c_clk); reset = 1'b1;
    @(posedge c_clk); #1; check("rresp_idle", {31'd0, out_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
